// File: rtl/hack_cpu_ws.sv
// Hack CPU with instruction/data wait states, retired-instruction counter and
// optional self-loop halt detection (enable with `define HACK_HALT_DETECT_EN).
module hack_cpu_ws #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  input  logic [15:0]       inM,
  input  logic              mem_ready,
  output logic [15:0]       outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  instret,
  output logic              halted
);

  // Handshake: instr_valid qualifies instruction for the current cycle; an
  // instruction touching data memory also needs mem_ready in the same cycle,
  // otherwise the CPU stalls with all requests (writeM, addressM) held steady.

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  logic        is_c;
  logic        sel_m;
  logic [5:0]  ctl;
  logic        dst_a, dst_d, dst_m;
  logic [2:0]  jmp_bits;
  logic [15:0] alu_x, alu_y, alu_r;
  logic        alu_zr, alu_ng;
  logic        take_jump;
  logic        mem_access;
  logic        commit;
  logic        halt_hit;
  logic [ADDR_W-1:0] pc_next;

  assign is_c     = instruction[15];
  assign sel_m    = instruction[12];
  assign ctl      = instruction[11:6];
  assign dst_a    = instruction[5];
  assign dst_d    = instruction[4];
  assign dst_m    = instruction[3];
  assign jmp_bits = instruction[2:0];

  // Hack ALU: ctl = {zx, nx, zy, ny, f, no}
  always_comb begin
    alu_x = d_reg;
    alu_y = sel_m ? inM : a_reg;
    if (ctl[5]) alu_x = '0;
    if (ctl[4]) alu_x = ~alu_x;
    if (ctl[3]) alu_y = '0;
    if (ctl[2]) alu_y = ~alu_y;
    alu_r = ctl[1] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ctl[0]) alu_r = ~alu_r;
  end

  assign alu_zr = (alu_r == 16'h0000);
  assign alu_ng = alu_r[15];
  assign outM   = alu_r;

  assign take_jump = is_c & ((jmp_bits[2] & alu_ng) |
                             (jmp_bits[1] & alu_zr) |
                             (jmp_bits[0] & ~alu_ng & ~alu_zr));

  assign mem_access = is_c & (sel_m | dst_m);
  assign commit     = instr_valid & (state == RUN) & (~mem_access | mem_ready);
  assign writeM     = rst_n & instr_valid & is_c & dst_m & (state == RUN);
  assign addressM   = a_reg[ADDR_W-1:0];

  // Jump target is the A value before this instruction writes A.
  assign pc_next = take_jump ? a_reg[ADDR_W-1:0] : pc + ADDR_W'(1);

`ifdef HACK_HALT_DETECT_EN
  assign halt_hit = is_c & (jmp_bits == 3'b111) & (a_reg[ADDR_W-1:0] == pc);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      a_reg   <= '0;
      d_reg   <= '0;
      pc      <= '0;
      instret <= '0;
`ifdef HACK_HALT_DETECT_EN
      halted  <= 1'b0;
`endif
    end else if (commit) begin
      if (!is_c) begin
        a_reg <= {1'b0, instruction[14:0]};
      end else begin
        if (dst_a) a_reg <= alu_r;
        if (dst_d) d_reg <= alu_r;
      end
      pc <= pc_next;
      if (instret != '1) instret <= instret + CNT_W'(1);
      if (halt_hit) begin
        state <= HALT;
`ifdef HACK_HALT_DETECT_EN
        halted <= 1'b1;
`endif
      end
    end
  end

endmodule
